// File: rtl/h2f_ipc_scheduler.sv
// h2f_ipc_scheduler: round-robin arbiter that shares one H2F IPC dispatcher among NUM_REQ requesters.
// Optional dispatcher watchdog is enabled by defining IPC_SCHED_TIMEOUT_EN.
`ifndef IPC_TOKEN_WIDTH
`define IPC_TOKEN_WIDTH 24
`endif

module h2f_ipc_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ*`IPC_TOKEN_WIDTH-1:0] REQ_TOKEN,
  input  logic [NUM_REQ-1:0]                  REQ_VALID,
  output logic [NUM_REQ-1:0]                  REQ_READY,
  output logic [NUM_REQ-1:0]                  REQ_DONE,
  output logic [NUM_REQ-1:0]                  REQ_ERR,
  output logic [`IPC_TOKEN_WIDTH-1:0]         TOKEN,
  output logic                                START,
  input  logic                                IDLE,
  output logic                                BUSY,
  output logic [IDX_W-1:0]                    GRANT_IDX
);

  localparam int W = `IPC_TOKEN_WIDTH;

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("h2f_ipc_scheduler: illegal parameter value");
  end

  typedef enum logic [1:0] {S_ARB, S_START, S_WAIT} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     cand;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_found;
  logic                 wait_expired;
  logic                 cmd_finish;
  logic [W-1:0]         tok_arr [NUM_REQ];
  logic [W-1:0]         token_d;
  logic [IDX_W-1:0]     grant_d;
  logic                 start_d;
  logic [NUM_REQ-1:0]   ready_d;
  logic [NUM_REQ-1:0]   done_d;
  logic [NUM_REQ-1:0]   grant_onehot;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_tok
    assign tok_arr[i] = REQ_TOKEN[i*W +: W];
  end

  assign grant_onehot = NUM_REQ'(1) << GRANT_IDX;
  assign cmd_finish   = (state_q == S_WAIT) && (IDLE || wait_expired);

  // Rotating search: first valid requester at or above ptr, wrapping to 0.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!arb_found && REQ_VALID[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ARB:   if (IDLE && arb_found) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (IDLE || wait_expired) state_d = S_ARB;
      default: state_d = S_ARB;
    endcase
  end

  always_comb begin
    token_d = TOKEN;
    grant_d = GRANT_IDX;
    ptr_d   = ptr_q;
    start_d = 1'b0;
    ready_d = '0;
    done_d  = '0;
    case (state_q)
      S_ARB: begin
        if (IDLE && arb_found) begin
          token_d          = tok_arr[arb_idx];
          grant_d          = arb_idx;
          ready_d[arb_idx] = 1'b1;
          start_d          = 1'b1;
        end
      end
      S_WAIT: begin
        if (cmd_finish) begin
          done_d = grant_onehot;
          ptr_d  = (int'(GRANT_IDX) == NUM_REQ - 1) ? '0 : GRANT_IDX + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_ARB;
      ptr_q     <= '0;
      TOKEN     <= '0;
      GRANT_IDX <= '0;
      START     <= 1'b0;
      REQ_READY <= '0;
      REQ_DONE  <= '0;
      BUSY      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      TOKEN     <= token_d;
      GRANT_IDX <= grant_d;
      START     <= start_d;
      REQ_READY <= ready_d;
      REQ_DONE  <= done_d;
      BUSY      <= (state_d != S_ARB);
    end
  end

`ifdef IPC_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // The count is of completed S_WAIT cycles, so the limit is reached one short of TIMEOUT_CYCLES.
  assign wait_expired = !IDLE && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || state_q == S_START) begin
      wait_cnt <= '0;
    end else if (state_q == S_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      REQ_ERR <= '0;
    end else begin
      REQ_ERR <= (state_q == S_WAIT && wait_expired) ? grant_onehot : '0;
    end
  end
`else
  assign wait_expired = 1'b0;
  assign REQ_ERR      = '0;
`endif

endmodule

// File: tb/tb_h2f_ipc_scheduler.sv
// tb_h2f_ipc_scheduler: directed self-checking bench for the round-robin IPC scheduler.
// The watchdog section runs only when IPC_SCHED_TIMEOUT_EN is defined.
`ifndef IPC_TOKEN_WIDTH
`define IPC_TOKEN_WIDTH 24
`endif

module tb_h2f_ipc_scheduler;

  localparam int NREQ = 4;
  localparam int W    = `IPC_TOKEN_WIDTH;
  localparam int IW   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ*W-1:0] req_token;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_done;
  logic [NREQ-1:0]   req_err;
  logic [W-1:0]      token;
  logic              start;
  logic              idle;
  logic              busy;
  logic [IW-1:0]     grant_idx;

  int checks      = 0;
  int errors      = 0;
  int start_count = 0;

  logic [W-1:0] tok_led, tok_xyz, tok_r0, tok_r3, tok_rst;
  logic [W-1:0] rr_tok [NREQ];

  h2f_ipc_scheduler #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .REQ_TOKEN (req_token),
    .REQ_VALID (req_valid),
    .REQ_READY (req_ready),
    .REQ_DONE  (req_done),
    .REQ_ERR   (req_err),
    .TOKEN     (token),
    .START     (start),
    .IDLE      (idle),
    .BUSY      (busy),
    .GRANT_IDX (grant_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [NREQ-1:0] oneHot(input int i);
    return NREQ'(1) << i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic [NREQ-1:0] valid, input logic idle_v);
    reset     = rst;
    req_valid = valid;
    idle      = idle_v;
  endtask

  task automatic setToken(input int idx, input logic [W-1:0] value);
    req_token[idx*W +: W] = value;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkGrant(input string tag, input int idx, input logic [W-1:0] tok);
    checkOutput({tag, "_start"}, 64'(start), 64'd1);
    checkOutput({tag, "_ready"}, 64'(req_ready), 64'(oneHot(idx)));
    checkOutput({tag, "_grant"}, 64'(grant_idx), 64'(idx));
    checkOutput({tag, "_token"}, 64'(token), 64'(tok));
    checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
    checkOutput({tag, "_done"}, 64'(req_done), 64'd0);
  endtask

  task automatic checkQuiet(input string tag, input logic [NREQ-1:0] done_exp, input logic busy_exp);
    checkOutput({tag, "_start"}, 64'(start), 64'd0);
    checkOutput({tag, "_ready"}, 64'(req_ready), 64'd0);
    checkOutput({tag, "_done"}, 64'(req_done), 64'(done_exp));
    checkOutput({tag, "_busy"}, 64'(busy), 64'(busy_exp));
  endtask

  task automatic checkAllZero(input string tag);
    checkQuiet(tag, '0, 1'b0);
    checkOutput({tag, "_err"}, 64'(req_err), 64'd0);
    checkOutput({tag, "_token"}, 64'(token), 64'd0);
    checkOutput({tag, "_grant"}, 64'(grant_idx), 64'd0);
  endtask

  initial begin
    tok_led   = "led";
    tok_xyz   = "xyz";
    tok_r0    = "r0a";
    tok_r3    = "r3b";
    tok_rst   = "rst";
    rr_tok[0] = "aa0";
    rr_tok[1] = "bb1";
    rr_tok[2] = "cc2";
    rr_tok[3] = "dd3";
    req_token = '0;
    applyStimulus(1'b1, '0, 1'b1);
    tick();
    tick();
    $display("[TB] reset state");
    checkAllZero("reset");
    applyStimulus(1'b0, '0, 1'b1);
    tick();

    $display("[TB] single request");
    setToken(2, tok_led);
    applyStimulus(1'b0, 4'b0100, 1'b1);
    tick();
    checkGrant("single", 2, tok_led);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkQuiet($sformatf("single_wait%0d", i), '0, 1'b1);
      checkOutput("single_token_hold", 64'(token), 64'(tok_led));
    end
    applyStimulus(1'b0, 4'b0000, 1'b1);
    tick();
    checkQuiet("single_done", 4'b0100, 1'b0);
    tick();
    checkQuiet("single_after", '0, 1'b0);

    $display("[TB] round robin");
    applyStimulus(1'b1, '0, 1'b1);
    tick();
    for (int i = 0; i < NREQ; i++) setToken(i, rr_tok[i]);
    applyStimulus(1'b0, 4'b1111, 1'b1);
    for (int n = 0; n < 6; n++) begin
      tick();
      if (start) start_count++;
      checkGrant($sformatf("rr%0d", n), n % NREQ, rr_tok[n % NREQ]);
      applyStimulus(1'b0, (n == 5) ? 4'b0000 : 4'b1111, 1'b0);
      tick();
      if (start) start_count++;
      checkQuiet($sformatf("rr%0d_w1", n), '0, 1'b1);
      tick();
      if (start) start_count++;
      checkQuiet($sformatf("rr%0d_w2", n), '0, 1'b1);
      applyStimulus(1'b0, (n == 5) ? 4'b0000 : 4'b1111, 1'b1);
      tick();
      if (start) start_count++;
      checkQuiet($sformatf("rr%0d_done", n), oneHot(n % NREQ), 1'b0);
    end
    checkOutput("rr_start_count", 64'(start_count), 64'd6);
    tick();
    checkQuiet("rr_after", '0, 1'b0);

    $display("[TB] unknown token");
    setToken(1, tok_xyz);
    applyStimulus(1'b0, 4'b0010, 1'b1);
    tick();
    checkGrant("unk", 1, tok_xyz);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    tick();
    checkQuiet("unk_wait", '0, 1'b1);
    tick();
    checkQuiet("unk_done", 4'b0010, 1'b0);
    checkOutput("unk_err", 64'(req_err), 64'd0);

    $display("[TB] dispatcher busy");
    setToken(0, tok_r0);
    applyStimulus(1'b0, 4'b0001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkQuiet($sformatf("busy_hold%0d", i), '0, 1'b0);
    end
    applyStimulus(1'b0, 4'b0001, 1'b1);
    tick();
    checkGrant("busy_grant", 0, tok_r0);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    tick();
    checkQuiet("busy_wait", '0, 1'b1);
    tick();
    checkQuiet("busy_done", 4'b0001, 1'b0);

`ifdef IPC_SCHED_TIMEOUT_EN
    $display("[TB] watchdog");
    setToken(3, tok_r3);
    applyStimulus(1'b0, 4'b1000, 1'b1);
    tick();
    checkGrant("tmo", 3, tok_r3);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkQuiet($sformatf("tmo_wait%0d", i), '0, 1'b1);
      checkOutput("tmo_err_low", 64'(req_err), 64'd0);
    end
    tick();
    checkQuiet("tmo_done", 4'b1000, 1'b0);
    checkOutput("tmo_err", 64'(req_err), 64'(4'b1000));
    applyStimulus(1'b0, 4'b0100, 1'b1);
    tick();
    checkOutput("tmo_err_clear", 64'(req_err), 64'd0);
    tick();
    checkGrant("edge", 2, tok_led);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkQuiet($sformatf("edge_wait%0d", i), '0, 1'b1);
    end
    applyStimulus(1'b0, 4'b0000, 1'b1);
    tick();
    checkQuiet("edge_done", 4'b0100, 1'b0);
    checkOutput("edge_err", 64'(req_err), 64'd0);
`endif

    $display("[TB] reset during wait");
    setToken(1, tok_rst);
    setToken(3, tok_r3);
    applyStimulus(1'b0, 4'b0010, 1'b1);
    tick();
    checkGrant("rstw", 1, tok_rst);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    tick();
    checkQuiet("rstw_w1", '0, 1'b1);
    tick();
    checkQuiet("rstw_w2", '0, 1'b1);
    applyStimulus(1'b1, 4'b1001, 1'b1);
    tick();
    checkAllZero("rstw_reset");
    applyStimulus(1'b0, 4'b1001, 1'b1);
    tick();
    checkGrant("rstw_first", 0, tok_r0);
    applyStimulus(1'b0, 4'b1000, 1'b1);
    tick();
    checkQuiet("rstw_first_w", '0, 1'b1);
    tick();
    checkQuiet("rstw_first_done", 4'b0001, 1'b0);
    tick();
    checkGrant("rstw_second", 3, tok_r3);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    tick();
    tick();
    checkQuiet("rstw_second_done", 4'b1000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
